pipe_field_ctrl: RTL
====================

// Module: pipe_field_ctrl
// PURPOSE
//  Downstream consumer of the bird physics stage (YBird/XBird, Y grows upward).
//  Scrolls two pipe columns right-to-left on a divided tick, respawns them with
//  pseudo-random gap heights, scores each pipe the bird clears, and flags Lost on
//  pipe/floor/ceiling collision. Feeds the VGA renderer and the game top FSM.
// PARAMETERS
//  TICK_DIV      500000  clocks per scroll tick
//  SCROLL_STEP   2       pixels moved per tick
//  SCREEN_W      640     spawn X of pipe 0
//  PIPE_SPACING  320     X distance between pipes (pipe 1 spawns at SCREEN_W+PIPE_SPACING)
//  PIPE_W        60      pipe column width
//  GAP_H         160     vertical opening height
//  GAP_MIN       120     lowest gap bottom; GapY = GAP_MIN + lfsr[7:0]
//  BIRD_SIZE     20      bird bounding-box edge
//  CEIL_Y        600     ceiling; YBird+BIRD_SIZE >= CEIL_Y is a hit
// PORTS
//  Clk        in   1   system clock
//  Reset      in   1   synchronous, active-high
//  Start      in   1   leave IDLE, begin scrolling
//  Ack        in   1   leave LOST, return to IDLE
//  YBird      in   10  bird bottom-left Y
//  XBird      in   10  bird bottom-left X
//  Pipe0X     out  10  pipe 0 left edge
//  Pipe0GapY  out  10  pipe 0 gap bottom
//  Pipe1X     out  10  pipe 1 left edge
//  Pipe1GapY  out  10  pipe 1 gap bottom
//  Score      out  8   pipes cleared, saturates at 255
//  Running    out  1   high in RUN
//  Lost       out  1   high in LOST
// BEHAVIOUR
//  Reset: IDLE; Pipe0X=SCREEN_W, Pipe1X=SCREEN_W+PIPE_SPACING, both GapY=GAP_MIN+128,
//   Score=0, Running=0, Lost=0, tick counter=0, passed flags=0, lfsr=8'hA5.
//   Reset mid-RUN/LOST restores all of the above on the next edge.
//  States (one-hot): IDLE, RUN, LOST.
//  IDLE: reload reset values for pipes/score/counter each cycle (lfsr excepted);
//   Start -> RUN.
//  RUN: counter counts 0..TICK_DIV-1; on wrap (tick) each pipe X -= SCROLL_STEP.
//   Respawn: on tick, if PipeX < SCROLL_STEP then PipeX <= PipeX+2*PIPE_SPACING-SCROLL_STEP,
//   GapY <= GAP_MIN+lfsr, passed flag cleared. Both pipes respawning on one tick: pipe 0
//   takes current lfsr, pipe 1 takes lfsr rotated left by 4.
//   Score: when PipeX+PIPE_W < XBird and passed==0, Score+1 (sat.), passed<=1; one
//   increment per pipe per pass; both pipes same cycle -> +2.
//  Hit (combinational, current regs): YBird==0, or YBird+BIRD_SIZE>=CEIL_Y, or for either
//   pipe X-overlap ([XBird,XBird+BIRD_SIZE) vs [PipeX,PipeX+PIPE_W)) with
//   YBird<GapY or YBird+BIRD_SIZE>GapY+GAP_H. Width: sums computed in 11 bits.
//  Hit in RUN -> LOST at next edge; Lost/Running update that edge (1-cycle latency).
//   Hit has priority: same-edge scroll, respawn and score increment are suppressed.
//  LOST: pipes, Score frozen; Ack -> IDLE. Start ignored outside IDLE; Ack outside LOST.
//  lfsr: 8-bit Galois, taps x^8+x^6+x^5+x^4+1, advances every cycle in every state.
// STRUCTURE
//  flappy_pkg: state one-hot localparams, COORD_W=10, geometry defaults shared with
//   physics stage and renderer.
//  Sub-module lfsr8 (Clk, Reset, seed 8'hA5, q[7:0]); one instance.
//  Two pipe slots as identical always blocks or a generate over index 0..1.
// TESTING (TICK_DIV=4 in sim)
//  1 Reset -> Pipe0X=640, Pipe1X=960, Score=0, Running=0, Lost=0.
//  2 Start, bird (100,300), gaps 248 -> Running=1; 4 clocks later Pipe0X=638, Pipe1X=958.
//  3 Scroll Pipe0X to 0 -> next tick Pipe0X=638, Pipe0GapY=120+lfsr, passed cleared.
//  4 Bird X=100 safe in gap; Pipe0X reaches 38 -> Score=1, stays 1 until respawn.
//  5 YBird=0 in RUN -> Lost=1 next cycle, Pipe0X frozen; Ack -> IDLE, Score=0, Pipe0X=640.
//  6 Hit on same edge as score/tick -> LOST, Score and PipeX unchanged; Reset mid-RUN ->
//    reset values next edge.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared geometry, coordinate type and FSM encoding
// for the bird physics, pipe field and renderer stages.
package flappy_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_SCROLL_STEP  = 2;
  localparam int DEF_SCREEN_W     = 640;
  localparam int DEF_PIPE_SPACING = 320;
  localparam int DEF_PIPE_W       = 60;
  localparam int DEF_GAP_H        = 160;
  localparam int DEF_GAP_MIN      = 120;
  localparam int DEF_BIRD_SIZE    = 20;
  localparam int DEF_CEIL_Y       = 600;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_RUN  = 3'b010,
    S_LOST = 3'b100
  } state_e;

  function automatic logic [7:0] rotl4(
    input logic [7:0] v
  );
    return {v[3:0], v[7:4]};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Galois LFSR, x^8+x^6+x^5+x^4+1,
// free-running every cycle after reset.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  always_comb begin
    q_d = {1'b0, q_q[7:1]};
    if (q_q[0]) q_d = q_d ^ 8'hB8;
  end

  always_ff @(posedge Clk) begin
    if (Reset) q_q <= SEED;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_field_ctrl.sv
// Scrolling pipe pair: tick divider, respawn,
// scoring and collision detection feeding the game FSM.
module pipe_field_ctrl
  import flappy_pkg::*;
#(
  parameter int TICK_DIV     = 500000,
  parameter int SCROLL_STEP  = DEF_SCROLL_STEP,
  parameter int SCREEN_W     = DEF_SCREEN_W,
  parameter int PIPE_SPACING = DEF_PIPE_SPACING,
  parameter int PIPE_W       = DEF_PIPE_W,
  parameter int GAP_H        = DEF_GAP_H,
  parameter int GAP_MIN      = DEF_GAP_MIN,
  parameter int BIRD_SIZE    = DEF_BIRD_SIZE,
  parameter int CEIL_Y       = DEF_CEIL_Y
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Ack,
  input  logic [COORD_W-1:0] YBird,
  input  logic [COORD_W-1:0] XBird,
  output logic [COORD_W-1:0] Pipe0X,
  output logic [COORD_W-1:0] Pipe0GapY,
  output logic [COORD_W-1:0] Pipe1X,
  output logic [COORD_W-1:0] Pipe1GapY,
  output logic [7:0]         Score,
  output logic               Running,
  output logic               Lost
);

  localparam int CNT_W = $clog2(TICK_DIV + 1);

  localparam coord_t X0   = coord_t'(SCREEN_W);
  localparam coord_t X1   = coord_t'(SCREEN_W + PIPE_SPACING);
  localparam coord_t GAP0 = coord_t'(GAP_MIN + 128);
  localparam coord_t RESP = coord_t'(2 * PIPE_SPACING - SCROLL_STEP);
  localparam coord_t STEP = coord_t'(SCROLL_STEP);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  coord_t           px_q  [2];
  coord_t           gap_q [2];
  logic [1:0]       pass_q;
  logic [7:0]       score_q;
  logic [7:0]       lfsr;

  logic        tick, hit, reload, adv;
  logic [1:0]  ovl, phit, clr, resp;
  logic [10:0] yb_top, xb_r;
  logic [10:0] px_r  [2];
  logic [10:0] gap_t [2];
  coord_t      gap_new [2];
  logic [8:0]  score_sum;
  logic [7:0]  score_d;

  lfsr8 #(.SEED(8'hA5)) u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .q     (lfsr)
  );

  // All sums are 11 bits so edges near 1023 cannot wrap.
  always_comb begin
    tick   = cnt_q == CNT_W'(TICK_DIV - 1);
    yb_top = {1'b0, YBird} + 11'(BIRD_SIZE);
    xb_r   = {1'b0, XBird} + 11'(BIRD_SIZE);
    for (int i = 0; i < 2; i++) begin
      px_r[i]  = {1'b0, px_q[i]} + 11'(PIPE_W);
      gap_t[i] = {1'b0, gap_q[i]} + 11'(GAP_H);
      ovl[i]   = ({1'b0, XBird} < px_r[i])
               && ({1'b0, px_q[i]} < xb_r);
      phit[i]  = ovl[i] && ((YBird < gap_q[i])
               || (yb_top > gap_t[i]));
      clr[i]   = (px_r[i] < {1'b0, XBird})
               && !pass_q[i];
      resp[i]  = tick && (px_q[i] < STEP);
    end
    hit = (YBird == '0)
        || (yb_top >= 11'(CEIL_Y))
        || (|phit);
    gap_new[0] = coord_t'(GAP_MIN) + coord_t'(lfsr);
    gap_new[1] = coord_t'(GAP_MIN)
               + coord_t'(resp[0] ? rotl4(lfsr) : lfsr);
    score_sum  = {1'b0, score_q} + 9'(clr[0]) + 9'(clr[1]);
    score_d    = score_sum[8] ? 8'hFF : score_sum[7:0];
    reload     = (state_q == S_IDLE)
               || ((state_q == S_LOST) && Ack);
    adv        = (state_q == S_RUN) && !hit;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (Start) state_q <= S_RUN;
        S_RUN:   if (hit)   state_q <= S_LOST;
        S_LOST:  if (Ack)   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset || reload) begin
      cnt_q    <= '0;
      px_q[0]  <= X0;
      px_q[1]  <= X1;
      gap_q[0] <= GAP0;
      gap_q[1] <= GAP0;
      pass_q   <= '0;
      score_q  <= '0;
    end else if (adv) begin
      cnt_q   <= tick ? '0 : cnt_q + CNT_W'(1);
      score_q <= score_d;
      for (int i = 0; i < 2; i++) begin
        if (resp[i]) begin
          px_q[i]   <= px_q[i] + RESP;
          gap_q[i]  <= gap_new[i];
          pass_q[i] <= 1'b0;
        end else begin
          if (tick)   px_q[i]   <= px_q[i] - STEP;
          if (clr[i]) pass_q[i] <= 1'b1;
        end
      end
    end
  end

  assign Pipe0X    = px_q[0];
  assign Pipe0GapY = gap_q[0];
  assign Pipe1X    = px_q[1];
  assign Pipe1GapY = gap_q[1];
  assign Score     = score_q;
  assign Running   = state_q == S_RUN;
  assign Lost      = state_q == S_LOST;

endmodule
